// File: rtl/swg_pkg.sv
// Shared types and helpers for the sliding-window generator.
// Holds the FSM state enum, the coordinate type and the tap-index helper.
package swg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } swg_state_e;

    typedef logic [15:0] coord_t;

    // Flat tap position of channel c, window row r, window column k.
    function automatic int unsigned tap_idx(
        input int unsigned c,
        input int unsigned r,
        input int unsigned k,
        input int unsigned kk
    );
        return c * kk * kk + r * kk + k;
    endfunction

endpackage

// File: rtl/swg_line_ram.sv
// One line buffer: single write port, single read port.
// Read data is registered, so it lags the read address by one cycle.
module swg_line_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage write and registered read; contents are masked downstream.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sliding_window_gen.sv
// KxK sliding-window generator with same-padding over a streamed raster.
// Optional stride-2 output decimation is enabled by defining SWG_STRIDE2_EN.
module sliding_window_gen
    import swg_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_WIDTH    = 256,
    parameter int MAX_HEIGHT   = 256,
    parameter int K            = 3
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [15:0]                            i_cfg_width,
    input  logic [15:0]                            i_cfg_height,
    input  logic                                   i_start,
`ifdef SWG_STRIDE2_EN
    input  logic                                   i_cfg_stride2,
`endif
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]     s_data,
    output logic                                   m_valid,
    input  logic                                   m_ready,
    output logic [NUM_CHANNELS*K*K*DATA_WIDTH-1:0] m_data,
    output logic                                   m_last,
    output logic                                   o_busy,
    output logic                                   o_cfg_err
);

    localparam int P  = (K - 1) / 2;
    localparam int PW = NUM_CHANNELS * DATA_WIDTH;
    localparam int MW = NUM_CHANNELS * K * K * DATA_WIDTH;
    localparam int NL = K - 1;
    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    localparam logic [31:0] LP_MIN  = 32'(P + 1);
    localparam logic [31:0] LP_WMAX = 32'(MAX_WIDTH);
    localparam logic [31:0] LP_HMAX = 32'(MAX_HEIGHT);

    swg_state_e r_state;
    swg_state_e w_next_state;

    coord_t r_w;
    coord_t r_h;
    coord_t r_vx;
    coord_t r_vy;
    coord_t r_xlast;
    coord_t r_ylast;
    logic   r_stride2;
    logic   r_scan_done;
    logic   r_last_acc;
    logic   r_cfg_err;

    logic          r_m_valid;
    logic          r_m_last;
    logic [MW-1:0] r_m_data;

    logic [PW-1:0] r_win [K][K];
    logic [PW-1:0] w_win_nxt [K][K];
    logic [PW-1:0] w_col [K];
    logic [MW-1:0] w_pack;
    logic [K-1:0]  w_col_ok;
    logic [K-1:0]  w_row_ok;

    logic [PW-1:0] w_ram_rd [NL];
    logic [PW-1:0] w_ram_wd [NL];
    logic          w_ram_we;
    logic [AW-1:0] w_waddr;
    logic [AW-1:0] w_raddr;

    logic          w_stride_in;
    logic          w_cfg_ok;
    logic          w_start_ok;
    logic [16:0]   w_col_last;
    logic [16:0]   w_row_last;
    logic          w_vx_end;
    logic          w_vy_end;
    logic          w_final;
    logic          w_real;
    logic          w_last_real;
    coord_t        w_cx;
    coord_t        w_cy;
    coord_t        w_vx_nxt;
    logic          w_emit;
    logic          w_slot_free;
    logic          w_slot_ok;
    logic          w_active;
    logic          w_in_ok;
    logic          w_step;
    logic          w_last_done;
    logic          w_scan_end;
    logic [PW-1:0] w_pix_in;

`ifdef SWG_STRIDE2_EN
    assign w_stride_in = i_cfg_stride2;
`else
    assign w_stride_in = 1'b0;
`endif

    assign w_cfg_ok =
        ({16'd0, i_cfg_width}  >= LP_MIN) &&
        ({16'd0, i_cfg_width}  <= LP_WMAX) &&
        ({16'd0, i_cfg_height} >= LP_MIN) &&
        ({16'd0, i_cfg_height} <= LP_HMAX);
    assign w_start_ok = (r_state == ST_IDLE) && i_start && w_cfg_ok;

    // Raster position bookkeeping over the padded (W+P)x(H+P) scan.
    assign w_col_last  = {1'b0, r_w} + 17'(P) - 17'd1;
    assign w_row_last  = {1'b0, r_h} + 17'(P) - 17'd1;
    assign w_vx_end    = ({1'b0, r_vx} == w_col_last);
    assign w_vy_end    = ({1'b0, r_vy} == w_row_last);
    assign w_final     = w_vx_end && w_vy_end;
    assign w_real      = (r_vx < r_w) && (r_vy < r_h);
    assign w_last_real = (r_vx == r_w - 16'd1) && (r_vy == r_h - 16'd1);
    assign w_cx        = r_vx - 16'(P);
    assign w_cy        = r_vy - 16'(P);

    assign w_emit = (r_vx >= 16'(P)) && (r_vy >= 16'(P)) &&
                    (!r_stride2 || (!w_cx[0] && !w_cy[0]));

    // Decimated steps never occupy the output slot, so they need not wait.
    assign w_slot_free = !r_m_valid || m_ready;
    assign w_slot_ok   = w_slot_free || (r_stride2 && !w_emit);
    assign w_active    = (r_state == ST_RUN) ||
                         ((r_state == ST_FLUSH) && !r_scan_done);
    assign w_in_ok     = w_real ? s_valid : 1'b1;
    assign w_step      = w_active && w_in_ok && w_slot_ok;

    assign w_last_done = r_last_acc || (r_m_valid && m_ready && r_m_last);
    assign w_scan_end  = r_scan_done || (w_step && w_final);

    assign w_pix_in = w_real ? s_data : '0;

    // Image columns >= W are always masked, so they are never stored.
    assign w_vx_nxt = w_step ? (w_vx_end ? 16'd0 : r_vx + 16'd1) : r_vx;
    assign w_raddr  = (w_vx_nxt < r_w) ? w_vx_nxt[AW-1:0] : '0;
    assign w_waddr  = r_vx[AW-1:0];
    assign w_ram_we = w_step && (r_vx < r_w);

    // Cascade: each line RAM feeds the previous row into the next one.
    always_comb begin
        for (int j = 0; j < NL; j++) begin
            w_ram_wd[j] = '0;
        end
        w_ram_wd[0] = w_pix_in;
        for (int j = 1; j < NL; j++) begin
            w_ram_wd[j] = w_ram_rd[j-1];
        end
    end

    for (genvar j = 0; j < NL; j++) begin : g_line
        swg_line_ram #(
            .DEPTH (MAX_WIDTH),
            .WIDTH (PW),
            .AW    (AW)
        ) u_line_ram (
            .clk     (clk),
            .i_we    (w_ram_we),
            .i_waddr (w_waddr),
            .i_wdata (w_ram_wd[j]),
            .i_raddr (w_raddr),
            .o_rdata (w_ram_rd[j])
        );
    end

    // Shift the window left and append the freshly assembled column.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            w_col[r] = '0;
        end
        w_col[K-1] = w_pix_in;
        for (int r = 0; r < K - 1; r++) begin
            w_col[r] = w_ram_rd[K-2-r];
        end
        for (int r = 0; r < K; r++) begin
            for (int k = 0; k < K; k++) begin
                w_win_nxt[r][k] = (k < K - 1) ? r_win[r][k+1] : w_col[r];
            end
        end
    end

    // Same-padding masks: tap column vx+k-2P and tap row vy+r-2P.
    always_comb begin
        for (int k = 0; k < K; k++) begin
            w_col_ok[k] =
                ({1'b0, r_vx} + 17'(k) >= 17'(2 * P)) &&
                ({1'b0, r_vx} + 17'(k) < {1'b0, r_w} + 17'(2 * P));
            w_row_ok[k] =
                ({1'b0, r_vy} + 17'(k) >= 17'(2 * P)) &&
                ({1'b0, r_vy} + 17'(k) < {1'b0, r_h} + 17'(2 * P));
        end
    end

    // Pack the masked window into the channel-major output layout.
    always_comb begin
        w_pack = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int r = 0; r < K; r++) begin
                for (int k = 0; k < K; k++) begin
                    if (w_row_ok[r] && w_col_ok[k]) begin
                        w_pack[tap_idx(c, r, k, K) * DATA_WIDTH +: DATA_WIDTH] =
                            w_win_nxt[r][k][c * DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic and status outputs.
    always_comb begin
        w_next_state = r_state;
        s_ready      = 1'b0;
        o_busy       = (r_state != ST_IDLE);
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                s_ready = w_real && w_slot_ok;
                if (w_step && w_real && w_last_real) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_last_done && w_scan_end) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Config latch, raster counters and end-of-frame flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w         <= '0;
            r_h         <= '0;
            r_vx        <= '0;
            r_vy        <= '0;
            r_xlast     <= '0;
            r_ylast     <= '0;
            r_stride2   <= 1'b0;
            r_scan_done <= 1'b0;
            r_last_acc  <= 1'b0;
        end else if (w_start_ok) begin
            r_w         <= i_cfg_width;
            r_h         <= i_cfg_height;
            r_vx        <= '0;
            r_vy        <= '0;
            r_stride2   <= w_stride_in;
            r_xlast     <= (i_cfg_width - 16'd1) &
                           (w_stride_in ? 16'hFFFE : 16'hFFFF);
            r_ylast     <= (i_cfg_height - 16'd1) &
                           (w_stride_in ? 16'hFFFE : 16'hFFFF);
            r_scan_done <= 1'b0;
            r_last_acc  <= 1'b0;
        end else begin
            if (w_step) begin
                r_vx <= w_vx_nxt;
                if (w_vx_end) begin
                    r_vy <= w_vy_end ? 16'd0 : r_vy + 16'd1;
                end
                if (w_final) begin
                    r_scan_done <= 1'b1;
                end
            end
            if (r_m_valid && m_ready && r_m_last) begin
                r_last_acc <= 1'b1;
            end
        end
    end

    // Window shift register advances once per raster step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < K; r++) begin
                for (int k = 0; k < K; k++) begin
                    r_win[r][k] <= '0;
                end
            end
        end else if (w_step) begin
            r_win <= w_win_nxt;
        end
    end

    // Output slot: load on an emitting step, hold until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
        end else if (w_step && w_emit) begin
            r_m_valid <= 1'b1;
            r_m_last  <= (w_cx == r_xlast) && (w_cy == r_ylast);
            r_m_data  <= w_pack;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end
    end

    // Rejected start pulses the error flag for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= (r_state == ST_IDLE) && i_start && !w_cfg_ok;
        end
    end

    assign m_valid   = r_m_valid;
    assign m_last    = r_m_last;
    assign m_data    = r_m_data;
    assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_sliding_window_gen.sv
// Randomized bench for sliding_window_gen against a padded-convolution
// window model computed directly from the stored input frame.
module tb_sliding_window_gen;

    localparam int NC   = 8;
    localparam int DW   = 8;
    localparam int K    = 3;
    localparam int P    = (K - 1) / 2;
    localparam int MAXW = 256;
    localparam int MAXH = 256;
    localparam int PW   = NC * DW;
    localparam int MW   = NC * K * K * DW;

    logic          clk;
    logic          rst_n;
    logic [15:0]   i_cfg_width;
    logic [15:0]   i_cfg_height;
    logic          i_start;
`ifdef SWG_STRIDE2_EN
    logic          i_cfg_stride2;
`endif
    logic          s_valid;
    logic          s_ready;
    logic [PW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [MW-1:0] m_data;
    logic          m_last;
    logic          o_busy;
    logic          o_cfg_err;

    int n_checks;
    int n_errors;

    logic [PW-1:0] frame_q[$];
    logic [MW-1:0] exp_q[$];
    bit            exp_last_q[$];
    logic [MW-1:0] got_q[$];

    sliding_window_gen #(
        .NUM_CHANNELS (NC),
        .DATA_WIDTH   (DW),
        .MAX_WIDTH    (MAXW),
        .MAX_HEIGHT   (MAXH),
        .K            (K)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cfg_width  (i_cfg_width),
        .i_cfg_height (i_cfg_height),
        .i_start      (i_start),
`ifdef SWG_STRIDE2_EN
        .i_cfg_stride2(i_cfg_stride2),
`endif
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .o_busy       (o_busy),
        .o_cfg_err    (o_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [MW-1:0] got,
                            input logic [MW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic gen_frame(input int w, input int h, input int pmode);
        logic [PW-1:0] px;
        frame_q.delete();
        for (int i = 0; i < w * h; i++) begin
            for (int c = 0; c < NC; c++) begin
                if (pmode == 0) px[c*DW +: DW] = DW'(i + 16 * c);
                else            px[c*DW +: DW] = DW'($urandom);
            end
            frame_q.push_back(px);
        end
    endtask

    // Expected windows: zero-padded neighbourhood of every emitted centre.
    task automatic build_expected(input int w, input int h, input bit st2);
        logic [MW-1:0] win;
        logic [PW-1:0] px;
        int ix, iy;
        exp_q.delete();
        exp_last_q.delete();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (st2 && (((x % 2) != 0) || ((y % 2) != 0))) continue;
                win = '0;
                for (int r = 0; r < K; r++) begin
                    for (int k = 0; k < K; k++) begin
                        ix = x + k - P;
                        iy = y + r - P;
                        if (ix >= 0 && ix < w && iy >= 0 && iy < h) begin
                            px = frame_q[iy * w + ix];
                            for (int c = 0; c < NC; c++) begin
                                win[(c*K*K + r*K + k)*DW +: DW] = px[c*DW +: DW];
                            end
                        end
                    end
                end
                exp_q.push_back(win);
                exp_last_q.push_back(1'b0);
            end
        end
        exp_last_q[exp_last_q.size() - 1] = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_s_ready"}, MW'(s_ready), MW'(0));
        check_eq({tag, "_m_valid"}, MW'(m_valid), MW'(0));
        check_eq({tag, "_m_last"}, MW'(m_last), MW'(0));
        check_eq({tag, "_busy"}, MW'(o_busy), MW'(0));
        check_eq({tag, "_cfg_err"}, MW'(o_cfg_err), MW'(0));
    endtask

    task automatic run_frame(input int w, input int h, input bit st2,
                             input int rmode, input int gap,
                             input int rst_at, input int pmode);
        int n, in_idx, out_idx, cyc, budget;
        bit stalled, done, held_last;
        logic [MW-1:0] held;
        gen_frame(w, h, pmode);
        build_expected(w, h, st2);
        got_q.delete();
        n = exp_q.size();
        budget = 20 * (w + 2) * (h + 2) + 200;
        @(posedge clk); #1;
        i_cfg_width  = 16'(w);
        i_cfg_height = 16'(h);
`ifdef SWG_STRIDE2_EN
        i_cfg_stride2 = st2;
`endif
        i_start = 1'b1;
        s_valid = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0;
        check_eq("busy_after_start", MW'(o_busy), MW'(1));
        in_idx = 0; out_idx = 0; cyc = 0;
        stalled = 1'b0; done = 1'b0; held = '0; held_last = 1'b0;
        while (cyc < budget) begin
            if (rst_at > 0 && in_idx >= rst_at) begin
                rst_n = 1'b0;
                i_start = 1'b0;
                s_valid = 1'b0;
                #1;
                check_reset_outputs("midframe_rst");
                @(posedge clk); @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((cyc % 3) == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            s_valid = (in_idx < w * h) && ($urandom_range(0, 99) >= gap);
            s_data  = s_valid ? frame_q[in_idx] : PW'({$urandom, $urandom});
            if (out_idx < n) begin
                i_start     = 1'($urandom_range(0, 7) == 0);
                i_cfg_width = 16'($urandom);
            end else begin
                i_start = 1'b0;
            end
            #1;
            check_eq("no_cfg_err_in_frame", MW'(o_cfg_err), MW'(0));
            if (stalled) begin
                check_eq("hold_valid", MW'(m_valid), MW'(1));
                check_eq("hold_data", m_data, held);
                check_eq("hold_last", MW'(m_last), MW'(held_last));
            end
            if (s_valid && s_ready) in_idx++;
            if (m_valid && m_ready) begin
                if (out_idx < n) begin
                    check_eq($sformatf("win%0d_data", out_idx), m_data, exp_q[out_idx]);
                    check_eq($sformatf("win%0d_last", out_idx), MW'(m_last),
                             MW'(exp_last_q[out_idx]));
                    got_q.push_back(m_data);
                end else begin
                    check_eq("extra_window", MW'(1), MW'(0));
                end
                out_idx++;
            end
            stalled   = m_valid && !m_ready;
            held      = m_data;
            held_last = m_last;
            if (out_idx >= n && !o_busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_start = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        check_eq("frame_done_in_budget", MW'(done), MW'(1));
        check_eq("window_count", MW'(out_idx), MW'(n));
        check_eq("pixels_accepted", MW'(in_idx), MW'(w * h));
    endtask

    function automatic int tap0(input logic [MW-1:0] win, input int idx);
        logic [DW-1:0] v;
        v = win[idx*DW +: DW];
        return int'(v);
    endfunction

    // Hand-derived channel-0 taps of the 4x3 index frame.
    task automatic check_index_frame(input string tag);
        int w0[9];
        int w11[9];
        w0  = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
        w11 = '{6, 7, 0, 10, 11, 0, 0, 0, 0};
        check_eq({tag, "_count"}, MW'(got_q.size()), MW'(12));
        if (got_q.size() == 12) begin
            for (int i = 0; i < 9; i++) begin
                check_eq($sformatf("%s_w0_tap%0d", tag, i),
                         MW'(tap0(got_q[0], i)), MW'(w0[i]));
                check_eq($sformatf("%s_w11_tap%0d", tag, i),
                         MW'(tap0(got_q[11], i)), MW'(w11[i]));
            end
        end
    endtask

    task automatic cfg_err_test(input int w, input int h);
        @(posedge clk); #1;
        i_cfg_width  = 16'(w);
        i_cfg_height = 16'(h);
        i_start = 1'b1;
        s_valid = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        check_eq($sformatf("cfg_err_pulse_%0dx%0d", w, h), MW'(o_cfg_err), MW'(1));
        check_eq("cfg_err_busy", MW'(o_busy), MW'(0));
        check_eq("cfg_err_s_ready", MW'(s_ready), MW'(0));
        @(posedge clk); #1;
        check_eq("cfg_err_cleared", MW'(o_cfg_err), MW'(0));
        check_eq("cfg_err_busy_after", MW'(o_busy), MW'(0));
        s_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        i_cfg_width = '0;
        i_cfg_height = '0;
        i_start = 1'b0;
`ifdef SWG_STRIDE2_EN
        i_cfg_stride2 = 1'b0;
`endif
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        run_frame(4, 3, 1'b0, 0, 0, 0, 0);
        check_index_frame("basic");

        run_frame(4, 3, 1'b0, 1, 30, 0, 0);
        check_index_frame("stall");

        run_frame(4, 3, 1'b0, 2, 20, 0, 1);
        run_frame(5, 2, 1'b0, 2, 20, 0, 1);

        cfg_err_test(1, 3);
        cfg_err_test(4, 1);
        cfg_err_test(257, 3);

        run_frame(4, 3, 1'b0, 0, 0, 5, 0);
        run_frame(4, 3, 1'b0, 0, 0, 0, 0);
        check_index_frame("after_rst");

        run_frame(2, 2, 1'b0, 2, 40, 0, 1);
        run_frame(7, 5, 1'b0, 2, 25, 0, 1);
        run_frame(MAXW, 2, 1'b0, 2, 10, 0, 1);

`ifdef SWG_STRIDE2_EN
        run_frame(4, 3, 1'b1, 0, 0, 0, 0);
        check_eq("stride_count", MW'(got_q.size()), MW'(4));
        run_frame(5, 4, 1'b1, 2, 30, 0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
